// File: rtl/atomic_count_reader.sv
// Two-beat 64-bit snapshot reader for the atomic event counter's 32-bit read port.
// Optional ATOMIC_RD_DELTA_EN adds delta_o, the difference between successive accepted snapshots.
module atomic_count_reader #(
  parameter int DATABUS = 32,
  parameter int CNTW    = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   rd_req_i,
  output logic                   rd_valid_o,
  input  logic                   rd_ready_i,
  output logic [2*DATABUS-1:0]   rd_data_o,
  output logic                   err_o,
  output logic [CNTW-1:0]        rd_cnt_o,
  output logic                   req_o,
  output logic                   atomic_o,
  input  logic                   ack_i,
  input  logic [DATABUS-1:0]     count_i
`ifdef ATOMIC_RD_DELTA_EN
  ,
  output logic [2*DATABUS-1:0]   delta_o
`endif
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_REQ_LO  = 3'd1;
  localparam logic [2:0] S_REQ_HI  = 3'd2;
  localparam logic [2:0] S_WAIT_HI = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  logic [2:0]         state_reg, state_next;
  logic               err_reg, err_next;
  logic [DATABUS-1:0] lo_reg, lo_next;
  logic [DATABUS-1:0] hi_reg, hi_next;
  logic [CNTW-1:0]    cnt_reg, cnt_next;
`ifdef ATOMIC_RD_DELTA_EN
  logic [2*DATABUS-1:0] delta_reg, delta_next;
  logic [2*DATABUS-1:0] prev_reg, prev_next;
`endif

  always_comb begin
    state_next = state_reg;
    err_next   = err_reg;
    lo_next    = lo_reg;
    hi_next    = hi_reg;
    cnt_next   = cnt_reg;
`ifdef ATOMIC_RD_DELTA_EN
    delta_next = delta_reg;
    prev_next  = prev_reg;
`endif
    case (state_reg)
      S_IDLE: begin
        if (rd_req_i) begin
          state_next = S_REQ_LO;
          err_next   = 1'b0;
        end
        // A stray ack in the same cycle as a new request still counts as an error.
        if (ack_i) err_next = 1'b1;
      end
      S_REQ_LO: begin
        state_next = S_REQ_HI;
        if (ack_i) err_next = 1'b1;
      end
      S_REQ_HI: begin
        if (ack_i) begin
          lo_next    = count_i;
          state_next = S_WAIT_HI;
        end else begin
          err_next   = 1'b1;
          state_next = S_IDLE;
        end
      end
      S_WAIT_HI: begin
        if (ack_i) begin
          hi_next    = count_i;
          state_next = S_DONE;
`ifdef ATOMIC_RD_DELTA_EN
          delta_next = {count_i, lo_reg} - prev_reg;
`endif
        end else begin
          err_next   = 1'b1;
          state_next = S_IDLE;
        end
      end
      S_DONE: begin
        if (ack_i) err_next = 1'b1;
        if (rd_ready_i) begin
          cnt_next   = cnt_reg + 1'b1;
          state_next = S_IDLE;
`ifdef ATOMIC_RD_DELTA_EN
          prev_next  = {hi_reg, lo_reg};
`endif
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= S_IDLE;
      err_reg   <= 1'b0;
      lo_reg    <= '0;
      hi_reg    <= '0;
      cnt_reg   <= '0;
`ifdef ATOMIC_RD_DELTA_EN
      delta_reg <= '0;
      prev_reg  <= '0;
`endif
    end else begin
      state_reg <= state_next;
      err_reg   <= err_next;
      lo_reg    <= lo_next;
      hi_reg    <= hi_next;
      cnt_reg   <= cnt_next;
`ifdef ATOMIC_RD_DELTA_EN
      delta_reg <= delta_next;
      prev_reg  <= prev_next;
`endif
    end
  end

  // Beat outputs decode straight from state so reset drops req_o without waiting for a clock.
  assign req_o      = (state_reg == S_REQ_LO) || (state_reg == S_REQ_HI);
  assign atomic_o   = (state_reg == S_REQ_LO);
  assign rd_valid_o = (state_reg == S_DONE);
  assign rd_data_o  = {hi_reg, lo_reg};
  assign err_o      = err_reg;
  assign rd_cnt_o   = cnt_reg;
`ifdef ATOMIC_RD_DELTA_EN
  assign delta_o    = delta_reg;
`endif

endmodule
